// File: rtl/ex_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_pkg
// Shared definitions for the EX-stage hazard / forwarding controller:
//   - forwarding-select encodings driven onto the ALU operand muxes
//   - the per-stage pipe tag carried alongside each in-flight instruction
//   - load/store opcode constants used by the decode side
//   - a helper that resolves one operand's forwarding source
// ---------------------------------------------------------------------------
package ex_hazard_ctrl_pkg;

  // Register address width carried in the pipe tags.
  localparam int TAG_AW = 5;

  // Operand mux selects in front of the ALU.
  localparam logic [1:0] FWD_REG   = 2'b00;  // register file value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB writeback value

  // Opcodes the decoder maps onto id_load / id_use_rt.
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // Destination tag of an in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] dest;
    logic              regwrite;
    logic              load;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_BUBBLE = '{valid: 1'b0, dest: '0, regwrite: 1'b0, load: 1'b0};

  // Source for one operand of the instruction about to enter EX. The
  // producer now in EX will sit in MEM next cycle (EX/MEM forward); the
  // producer now in MEM will sit in WB (MEM/WB forward). Checking EX first
  // makes the youngest producer win. A load still in EX cannot forward
  // yet; that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic ex_load,
                                          input logic hit_mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (hit_ex && !ex_load) sel = FWD_EXMEM;
    else if (hit_mem)       sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_match.sv
// ---------------------------------------------------------------------------
// hazard_match
// Combinational comparator: does the instruction described by 'tag' write
// register 'reg_addr'? Register zero never matches, since writes to it are
// discarded by the register file.
//   tag      in  pipe tag of one pipeline slot
//   reg_addr in  source register of the instruction in ID
//   hit      out slot produces a value for reg_addr
// ---------------------------------------------------------------------------
module hazard_match
  import ex_hazard_ctrl_pkg::*;
(
  input  pipe_tag_t         tag,
  input  logic [TAG_AW-1:0] reg_addr,
  output logic              hit
);

  assign hit = tag.valid & tag.regwrite & (tag.dest == reg_addr) & (reg_addr != '0);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl
// Hazard and forwarding controller for the EX-stage ALU datapath. Tracks
// the destination tags of the instructions in EX, MEM and WB, and produces
// registered operand forwarding selects, a load-use stall and a branch
// flush. An init window after reset suppresses forwarding and stalls while
// the pipeline fills with PC-init bubbles.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   id_valid       ID holds a real instruction
//   id_rs, id_rt   source registers of the ID instruction
//   id_use_rs/rt   ID instruction actually reads rs / rt
//   id_towrite     destination of the ID instruction
//   id_regwrite    ID instruction writes the register file
//   id_load        ID instruction is a load
//   branch_taken   branch in EX resolved taken
//   fwd_a_sel/b    registered operand selects for the instruction in EX
//   stall_id       hold PC and IF/ID, bubble into EX
//   flush_id       squash the IF/ID instruction
//   ex_bubble      EX slot holds a bubble
//   init_busy      init suppression window active
// ---------------------------------------------------------------------------
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = TAG_AW,
  parameter int INIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_towrite,
  input  logic              id_regwrite,
  input  logic              id_load,
  input  logic              branch_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_id,
  output logic              flush_id,
  output logic              ex_bubble,
  output logic              init_busy
);

  localparam int CNT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] init_cnt;
  pipe_tag_t        ex_tag, mem_tag, wb_tag;
  pipe_tag_t        id_tag;

  logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic load_use, advance;
  logic [1:0] sel_a_next, sel_b_next;

  // Tag comparators: EX/MEM slots against both ID source registers.
  hazard_match u_match_ex_rs  (.tag(ex_tag),  .reg_addr(id_rs), .hit(hit_ex_rs));
  hazard_match u_match_ex_rt  (.tag(ex_tag),  .reg_addr(id_rt), .hit(hit_ex_rt));
  hazard_match u_match_mem_rs (.tag(mem_tag), .reg_addr(id_rs), .hit(hit_mem_rs));
  hazard_match u_match_mem_rt (.tag(mem_tag), .reg_addr(id_rt), .hit(hit_mem_rt));

  assign init_busy = (init_cnt != '0);

  // A load in EX only has its data at the end of MEM, so a consumer right
  // behind it must wait one cycle; after that it picks the value up from WB.
  assign load_use = ex_tag.load & ((id_use_rs & hit_ex_rs) | (id_use_rt & hit_ex_rt));

  // Flush wins over stall: the squashed ID instruction must not hold the PC.
  assign stall_id  = ~init_busy & ~branch_taken & id_valid & load_use;
  assign flush_id  = branch_taken;
  assign advance   = id_valid & ~stall_id & ~branch_taken;
  assign ex_bubble = ~ex_tag.valid;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it holding its old value (no latch).
  always_comb begin
    id_tag          = TAG_BUBBLE;
    id_tag.valid    = 1'b1;
    id_tag.dest     = id_towrite;
    id_tag.regwrite = id_regwrite;
    id_tag.load     = id_load;
    sel_a_next      = fwd_pick(id_use_rs & hit_ex_rs, ex_tag.load, id_use_rs & hit_mem_rs);
    sel_b_next      = fwd_pick(id_use_rt & hit_ex_rt, ex_tag.load, id_use_rt & hit_mem_rt);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, which makes the EX->MEM->WB shift order-independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt  <= CNT_W'(INIT_CYCLES);
      ex_tag    <= TAG_BUBBLE;
      mem_tag   <= TAG_BUBBLE;
      wb_tag    <= TAG_BUBBLE;
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
    end else begin
      if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;

      // MEM->WB and EX->MEM always move; only the ID->EX step can bubble.
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      ex_tag  <= advance ? id_tag : TAG_BUBBLE;

      // Selects travel with the instruction; a bubble carries regfile selects.
      fwd_a_sel <= (advance && !init_busy) ? sel_a_next : FWD_REG;
      fwd_b_sel <= (advance && !init_busy) ? sel_b_next : FWD_REG;
    end
  end

endmodule
